// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state type for the 16-client round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_CLIENTS = 16;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/dec_4x16.sv
// 4-to-16 binary-to-one-hot decoder.
module dec_4x16 (
    input  logic [3:0]  sel,
    output logic [15:0] dec
);

    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_arb_16.sv
// Round-robin arbiter for 16 clients with hold timeout and a one-cycle
// turnaround gap between grants.
module rr_arb_16
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CLIENTS-1:0] req,
    input  logic                 done,
    output logic                 grant_vld,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [N_CLIENTS-1:0] grant_oh,
    output logic                 timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [IDX_W-1:0]    grant_idx_n;
    logic                grant_vld_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                timeout_n;
    logic [IDX_W-1:0]    sel_idx;
    logic [N_CLIENTS-1:0] dec_oh;

    // First set bit scanning upward from start, wrapping modulo 16.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CLIENTS-1:0] r,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = start;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            cand = start + i[IDX_W-1:0];
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign sel_idx = rr_pick(req, ptr);

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        grant_idx_n = grant_idx;
        grant_vld_n = grant_vld;
        hold_cnt_n  = hold_cnt;
        timeout_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    state_n     = S_GRANT;
                    grant_idx_n = sel_idx;
                    grant_vld_n = 1'b1;
                    hold_cnt_n  = HOLD_W'(1);
                end
            end
            S_GRANT: begin
                if (done || !req[grant_idx] || hold_cnt == HOLD_LIMIT) begin
                    state_n     = S_GAP;
                    grant_vld_n = 1'b0;
                    ptr_n       = grant_idx + IDX_W'(1);
                    hold_cnt_n  = '0;
                    // Only flag timeout when neither done nor withdrawal caused the release.
                    timeout_n   = !done && req[grant_idx];
                end else begin
                    hold_cnt_n  = hold_cnt + HOLD_W'(1);
                end
            end
            S_GAP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n     = S_IDLE;
                grant_vld_n = 1'b0;
                hold_cnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant_idx <= grant_idx_n;
            grant_vld <= grant_vld_n;
            hold_cnt  <= hold_cnt_n;
            timeout   <= timeout_n;
        end
    end

    dec_4x16 u_dec (
        .sel (grant_idx),
        .dec (dec_oh)
    );

    assign grant_oh = grant_vld ? dec_oh : '0;

endmodule

// File: tb/tb_rr_arb_16.sv
// Directed self-checking bench for rr_arb_16 (MAX_HOLD=8).
module tb_rr_arb_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        grant_vld;
    logic [3:0]  grant_idx;
    logic [15:0] grant_oh;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    rr_arb_16 #(.MAX_HOLD(8), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [3:0] ei, input logic et);
        logic [15:0] eo;
        eo = ev ? (16'h0001 << ei) : 16'h0000;
        checks++;
        assert (grant_vld === ev) else begin
            failures++;
            $error("FAIL %s grant_vld got=%0b exp=%0b", tag, grant_vld, ev);
        end
        checks++;
        assert (grant_oh === eo) else begin
            failures++;
            $error("FAIL %s grant_oh got=%04h exp=%04h", tag, grant_oh, eo);
        end
        checks++;
        assert (timeout === et) else begin
            failures++;
            $error("FAIL %s timeout got=%0b exp=%0b", tag, timeout, et);
        end
        if (ev) begin
            checks++;
            assert (grant_idx === ei) else begin
                failures++;
                $error("FAIL %s grant_idx got=%0d exp=%0d", tag, grant_idx, ei);
            end
        end
    endtask

    initial begin
        logic [3:0] order [6];
        order = '{4'd15, 4'd0, 4'd1, 4'd15, 4'd0, 4'd1};

        rst  = 1'b1;
        req  = 16'hFFFF;
        done = 1'b0;
        tick(); chk("reset1", 1'b0, 4'd0, 1'b0);
        tick(); chk("reset2", 1'b0, 4'd0, 1'b0);

        rst = 1'b0;
        tick(); chk("first_grant", 1'b1, 4'd0, 1'b0);
        done = 1'b1;
        tick(); chk("first_gap", 1'b0, 4'd0, 1'b0);
        done = 1'b0; req = 16'h0000;
        tick(); chk("idle_a", 1'b0, 4'd0, 1'b0);
        done = 1'b1;
        tick(); chk("done_in_idle", 1'b0, 4'd0, 1'b0);
        done = 1'b0;

        // single requester 5, released by done after 2 grant cycles
        req = 16'h0020;
        tick(); chk("single_grant", 1'b1, 4'd5, 1'b0);
        tick(); chk("single_hold", 1'b1, 4'd5, 1'b0);
        done = 1'b1;
        tick(); chk("single_gap", 1'b0, 4'd0, 1'b0);
        done = 1'b0; req = 16'h0060;
        tick(); chk("single_idle", 1'b0, 4'd0, 1'b0);
        tick(); chk("ptr_after_5", 1'b1, 4'd6, 1'b0);
        req = 16'h0000;
        tick(); chk("withdraw_gap", 1'b0, 4'd0, 1'b0);

        // rotation across the 15->0 wrap; ptr=7 on entry
        req = 16'h8003;
        tick(); chk("rot_idle0", 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick(); chk($sformatf("rot_grant%0d", k), 1'b1, order[k], 1'b0);
            done = 1'b1;
            tick(); chk($sformatf("rot_gap%0d", k), 1'b0, 4'd0, 1'b0);
            done = 1'b0;
            tick(); chk($sformatf("rot_idle%0d", k), 1'b0, 4'd0, 1'b0);
        end

        // forced release after 8 grant cycles; ptr=2 on entry
        req = 16'h0004;
        for (int k = 1; k <= 8; k++) begin
            tick(); chk($sformatf("to_hold%0d", k), 1'b1, 4'd2, 1'b0);
        end
        tick(); chk("to_pulse", 1'b0, 4'd0, 1'b1);
        tick(); chk("to_idle", 1'b0, 4'd0, 1'b0);
        tick(); chk("to_regrant", 1'b1, 4'd2, 1'b0);

        // done on the final hold cycle suppresses the timeout pulse
        for (int k = 2; k <= 8; k++) begin
            tick(); chk($sformatf("dt_hold%0d", k), 1'b1, 4'd2, 1'b0);
        end
        done = 1'b1;
        tick(); chk("dt_gap_no_to", 1'b0, 4'd0, 1'b0);
        done = 1'b0;
        tick(); chk("dt_idle", 1'b0, 4'd0, 1'b0);

        // withdrawal mid-grant; ptr=3 wraps round to 2
        tick(); chk("wd_grant", 1'b1, 4'd2, 1'b0);
        tick(); chk("wd_hold", 1'b1, 4'd2, 1'b0);
        req = 16'h0000;
        tick(); chk("wd_gap", 1'b0, 4'd0, 1'b0);
        tick(); chk("wd_idle", 1'b0, 4'd0, 1'b0);

        // reset during grant 9 clears ptr back to 0
        req = 16'h0200;
        tick(); chk("rm_grant9", 1'b1, 4'd9, 1'b0);
        req = 16'h0201; rst = 1'b1;
        tick(); chk("rm_reset", 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        tick(); chk("rm_after", 1'b1, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
